wdt_core: RTL and testbench

Watchdog timer core that sits directly downstream of the watchdog AXI register wrapper. It consumes the WDEN, WDLIVE and WTOCNT register values the wrapper drives and returns the WTO timeout flag that the wrapper consumes. It counts prescaled clock ticks while enabled and asserts WTO when the count passes the latched threshold. A software "kick" (rising edge on WDLIVE) restarts the count.

---
 rtl/wdt_core_if.sv | 14 +
 rtl/wdt_core.sv | 104 ++++++++++
 tb/tb_wdt_core.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wdt_core_if.sv
// Register-side bundle between the watchdog AXI wrapper and wdt_core.
// The wrapper (master) drives the control levels; the core (slave) returns status.
interface wdt_core_if #(
  parameter int CNT_W = 32
);
  logic             wden;
  logic             wdlive;
  logic [CNT_W-1:0] wtocnt;
  logic             wto;
  logic [CNT_W-1:0] wdt_cnt;

  modport master (output wden, wdlive, wtocnt, input  wto, wdt_cnt);
  modport slave  (input  wden, wdlive, wtocnt, output wto, wdt_cnt);
endinterface

// File: rtl/wdt_core.sv
// Watchdog core: counts prescaled ticks while enabled, raises a registered
// timeout flag once the count passes the threshold latched at enable/kick.
module wdt_core #(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wdt_core_if.slave  bus
);
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, COUNT, TIMEOUT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             wto_q, wto_d;
  logic             wdlive_q;
  logic             kick, tick;

  assign kick = bus.wdlive & ~wdlive_q;
  assign tick = (pcnt_q == PMAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      thr_q    <= '0;
      pcnt_q   <= '0;
      wto_q    <= 1'b0;
      wdlive_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      pcnt_q   <= pcnt_d;
      wto_q    <= wto_d;
      wdlive_q <= bus.wdlive;
    end
  end

  // Disable outranks kick, which outranks tick/timeout, in every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    pcnt_d  = pcnt_q;
    wto_d   = wto_q;
    if (!bus.wden) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
      wto_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = '0;
          pcnt_d  = '0;
          thr_d   = bus.wtocnt;
        end
        COUNT: begin
          if (kick) begin
            cnt_d  = '0;
            pcnt_d = '0;
            thr_d  = bus.wtocnt;
          end else begin
            pcnt_d = tick ? '0 : pcnt_q + PW'(1);
            // Compare before increment so cnt saturates at thr and never wraps.
            if (tick) begin
              if (cnt_q == thr_q) begin
                state_d = TIMEOUT;
                wto_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
        end
        TIMEOUT: begin
          if (kick) begin
            state_d = COUNT;
            cnt_d   = '0;
            pcnt_d  = '0;
            thr_d   = bus.wtocnt;
            wto_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          pcnt_d  = '0;
          wto_d   = 1'b0;
        end
      endcase
    end
  end

  assign bus.wto     = wto_q;
  assign bus.wdt_cnt = cnt_q;
endmodule

// File: tb/tb_wdt_core.sv
// Directed bench for wdt_core: a per-cycle vector table for the PRESCALE=1
// core plus hand sequences for kicks, prescale, saturation and async reset.
module tb_wdt_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wden = 1'b0;
  logic        wdlive = 1'b0;
  logic [31:0] wtocnt = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wdt_core_if #(.CNT_W(32)) if1 ();
  wdt_core_if #(.CNT_W(32)) if4 ();
  wdt_core_if #(.CNT_W(4))  ifs ();

  assign if1.wden = wden;  assign if1.wdlive = wdlive;  assign if1.wtocnt = wtocnt;
  assign if4.wden = wden;  assign if4.wdlive = wdlive;  assign if4.wtocnt = wtocnt;
  assign ifs.wden = wden;  assign ifs.wdlive = wdlive;  assign ifs.wtocnt = wtocnt[3:0];

  wdt_core #(.PRESCALE(1), .CNT_W(32)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  wdt_core #(.PRESCALE(4), .CNT_W(32)) dut4 (.clk_i(clk), .rst_i(rst), .bus(if4.slave));
  wdt_core #(.PRESCALE(1), .CNT_W(4))  duts (.clk_i(clk), .rst_i(rst), .bus(ifs.slave));

  typedef struct {
    logic        wden;
    logic        wdlive;
    logic [31:0] wtocnt;
    logic        exp_wto;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // {wden, wdlive, wtocnt, exp_wto, exp_cnt} after the edge the row is applied to
    tbl.push_back('{1'b0, 1'b0, 32'd5,   1'b0, 32'd0});
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b0, 32'd0}); // E0
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b0, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b0, 32'd2});
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b0, 32'd3});
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b0, 32'd4});
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b0, 32'd5});
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b1, 32'd5}); // E6 timeout
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b1, 32'd5});
    tbl.push_back('{1'b1, 1'b1, 32'd3,   1'b0, 32'd0}); // kick out of timeout, thr=3
    tbl.push_back('{1'b1, 1'b1, 32'd3,   1'b0, 32'd1});
    tbl.push_back('{1'b1, 1'b1, 32'd3,   1'b0, 32'd2});
    tbl.push_back('{1'b1, 1'b1, 32'd3,   1'b0, 32'd3});
    tbl.push_back('{1'b1, 1'b1, 32'd3,   1'b1, 32'd3});
    tbl.push_back('{1'b0, 1'b1, 32'd3,   1'b0, 32'd0}); // disable in timeout
    tbl.push_back('{1'b0, 1'b0, 32'd3,   1'b0, 32'd0});
    tbl.push_back('{1'b1, 1'b0, 32'd0,   1'b0, 32'd0}); // thr=0
    tbl.push_back('{1'b1, 1'b0, 32'd0,   1'b1, 32'd0});
    tbl.push_back('{1'b0, 1'b0, 32'd0,   1'b0, 32'd0});
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b0, 32'd0});
    tbl.push_back('{1'b1, 1'b0, 32'd5,   1'b0, 32'd1});
    tbl.push_back('{1'b0, 1'b0, 32'd5,   1'b0, 32'd0}); // disable in count
    tbl.push_back('{1'b1, 1'b0, 32'd3,   1'b0, 32'd0});
    tbl.push_back('{1'b1, 1'b0, 32'd100, 1'b0, 32'd1}); // threshold change ignored
    tbl.push_back('{1'b1, 1'b0, 32'd100, 1'b0, 32'd2});
    tbl.push_back('{1'b1, 1'b0, 32'd100, 1'b0, 32'd3});
    tbl.push_back('{1'b1, 1'b0, 32'd100, 1'b1, 32'd3});
    tbl.push_back('{1'b0, 1'b0, 32'd2,   1'b0, 32'd0});
    tbl.push_back('{1'b1, 1'b0, 32'd2,   1'b0, 32'd0});
    tbl.push_back('{1'b1, 1'b0, 32'd2,   1'b0, 32'd1});
    tbl.push_back('{1'b1, 1'b0, 32'd2,   1'b0, 32'd2});
    tbl.push_back('{1'b1, 1'b1, 32'd2,   1'b0, 32'd0}); // kick on the timeout edge wins
    tbl.push_back('{1'b1, 1'b1, 32'd2,   1'b0, 32'd1});
    tbl.push_back('{1'b1, 1'b1, 32'd2,   1'b0, 32'd2});
    tbl.push_back('{1'b1, 1'b1, 32'd2,   1'b1, 32'd2});
    tbl.push_back('{1'b0, 1'b0, 32'd2,   1'b0, 32'd0});

    // reset state
    #12;
    chk("reset_wto", {31'd0, if1.wto}, 32'd0);
    chk("reset_cnt", if1.wdt_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      wden = tbl[i].wden; wdlive = tbl[i].wdlive; wtocnt = tbl[i].wtocnt;
      step();
      chk($sformatf("tbl%0d_wto", i), {31'd0, if1.wto}, {31'd0, tbl[i].exp_wto});
      chk($sformatf("tbl%0d_cnt", i), if1.wdt_cnt, tbl[i].exp_cnt);
    end

    // periodic kicks keep the flag low
    wtocnt = 32'd10; wden = 1'b1;
    for (int c = 0; c < 200; c++) begin
      wdlive = ((c % 8) < 4);
      step();
      chk($sformatf("kick%0d_wto", c), {31'd0, if1.wto}, 32'd0);
    end
    wdlive = 1'b1;
    step();
    chk("lastkick_cnt", if1.wdt_cnt, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("hold%0d_wto", k), {31'd0, if1.wto}, (k == 11) ? 32'd1 : 32'd0);
      chk($sformatf("hold%0d_cnt", k), if1.wdt_cnt, (k >= 10) ? 32'd10 : k);
    end

    // all-ones threshold on 32-bit core; saturation on the 4-bit core
    wden = 1'b0; wdlive = 1'b0;
    step();
    wden = 1'b1; wtocnt = 32'hFFFF_FFFF;
    step();
    chk("ones_e0_cnt", if1.wdt_cnt, 32'd0);
    for (int k = 1; k <= 300; k++) begin
      step();
      chk($sformatf("ones%0d_cnt", k), if1.wdt_cnt, k);
      chk($sformatf("ones%0d_wto", k), {31'd0, if1.wto}, 32'd0);
      if (k <= 20) begin
        chk($sformatf("sat%0d_cnt", k), {28'd0, ifs.wdt_cnt}, (k >= 15) ? 32'd15 : k);
        chk($sformatf("sat%0d_wto", k), {31'd0, ifs.wto}, (k >= 16) ? 32'd1 : 32'd0);
      end
    end

    // PRESCALE=4, thr=2: ticks at E4, E8, E12
    wden = 1'b0;
    step();
    wden = 1'b1; wtocnt = 32'd2;
    step();
    chk("ps_e0_cnt", if4.wdt_cnt, 32'd0);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("ps%0d_cnt", k), if4.wdt_cnt, (k >= 8) ? 32'd2 : k / 4);
      chk($sformatf("ps%0d_wto", k), {31'd0, if4.wto}, (k >= 12) ? 32'd1 : 32'd0);
    end

    // async reset out of TIMEOUT, no clock edge needed
    chk("pre_rst_wto", {31'd0, if1.wto}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wto", {31'd0, if1.wto}, 32'd0);
    chk("async_rst_cnt", if1.wdt_cnt, 32'd0);
    chk("async_rst_wto4", {31'd0, if4.wto}, 32'd0);
    wden = 1'b0; wtocnt = 32'd0;
    #1 rst = 1'b0;
    step();
    chk("post_rst_idle_wto", {31'd0, if1.wto}, 32'd0);
    wden = 1'b1;
    step();
    chk("post_rst_e0_wto", {31'd0, if1.wto}, 32'd0);
    step();
    chk("post_rst_e1_wto", {31'd0, if1.wto}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
